// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair for the integer pipeline.
// Define MD_MADD_EN to build the MADD/MSUB accumulate path (md_op 6/7).
//
// state  | meaning
// S_IDLE | no operation in flight, busy=0, issues accepted
// S_RUN  | latched operation counting down, busy=1, hi/lo held
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;

    logic        w_issue_mul;
    logic        w_issue_div;
    logic        w_sgn;
    logic [63:0] w_ax;
    logic [63:0] w_bx;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    always_comb begin
        w_issue_mul = (md_op == 3'd0) || (md_op == 3'd1);
`ifdef MD_MADD_EN
        w_issue_mul = w_issue_mul || (md_op == 3'd6) || (md_op == 3'd7);
`endif
        w_issue_div = (md_op == 3'd2) || (md_op == 3'd3);
    end

    // Signed ops are MULT, DIV, MADD, MSUB (op bit0 clear, or 6/7).
    assign w_sgn = ~r_op[0] | (r_op[2] & r_op[1]);

    assign w_ax   = w_sgn ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_bx   = w_sgn ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod = w_ax * w_bx;

    // Divide on magnitudes so 0x80000000 / -1 needs no special case.
    assign w_a_neg = w_sgn & r_a[31];
    assign w_b_neg = w_sgn & r_b[31];
    assign w_ua    = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_ub    = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_den   = (r_b == 32'd0) ? 32'd1 : w_ub;
    assign w_q_mag = w_ua / w_den;
    assign w_r_mag = w_ua % w_den;
    assign w_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

`ifdef MD_MADD_EN
    logic [63:0] w_acc;
    // hi/lo cannot change during RUN, so the current pair equals the pair at issue.
    assign w_acc = r_op[0] ? ({hi, lo} - w_prod) : ({hi, lo} + w_prod);
`endif

    assign md_stall = start | busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_issue_mul || w_issue_div) begin
                            r_a     <= A;
                            r_b     <= B;
                            r_op    <= md_op;
                            r_cnt   <= w_issue_div ? 4'd10 : 4'd5;
                            busy    <= 1'b1;
                            r_state <= S_RUN;
                        end else if (md_op == 3'd4) begin
                            hi <= A;
                        end else if (md_op == 3'd5) begin
                            lo <= A;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                        case (r_op)
                            3'd0, 3'd1: {hi, lo} <= w_prod;
                            3'd2, 3'd3: begin
                                if (r_b != 32'd0) {hi, lo} <= {w_rem, w_quo};
                            end
`ifdef MD_MADD_EN
                            3'd6, 3'd7: {hi, lo} <= w_acc;
`endif
                            default: ;
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide: clk  input  1  single rising-edge clock.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  input  1  EX-stage request to issue md_op this cycle.
REQ-004 SHALL provide: md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-005 SHALL provide: A  input  32  forwarded rs operand from ID/EX.
REQ-006 SHALL provide: B  input  32  forwarded rt operand from ID/EX.
REQ-007 SHALL provide: busy  output  1  registered; high while a multi-cycle operation is in flight.
REQ-008 SHALL provide: md_stall  output  1  combinational start|busy, consumed by the hazard unit.
REQ-009 SHALL provide: hi  output  32  HI register, registered.
REQ-010 SHALL provide: lo  output  32  LO register, registered.

Function
REQ-011 SHALL accept an issue only at a posedge where start=1 and busy=0, and SHALL ignore start while busy=1.
REQ-012 SHALL, on an accepted MULT/MULTU/MADD/MSUB, latch A, B and md_op and run for exactly 5 cycles, with busy=1 for those 5 cycles.
REQ-013 SHALL, on an accepted DIV/DIVU, latch A, B and md_op and run for exactly 10 cycles, with busy=1 for those 10 cycles.
REQ-014 SHALL use a down-counter loaded with 5 or 10 at issue and decremented at each busy edge; at the edge where the count reaches 0 it SHALL write hi/lo and clear busy at that same edge.
REQ-015 SHALL run two states: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on an accepted multi-cycle op, RUN->IDLE when the counter expires.
REQ-016 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned, with {hi,lo}=product.
REQ-017 SHALL compute DIV with a signed quotient truncated toward zero and a remainder carrying the dividend's sign, with lo=quotient and hi=remainder; DIVU SHALL be unsigned.
REQ-018 SHALL produce lo=0x80000000 and hi=0 for DIV 0x80000000 / 0xFFFFFFFF.
REQ-019 SHALL leave hi and lo unchanged on completion of DIV/DIVU with B=0, with busy still lasting 10 cycles.
REQ-020 SHALL write MTHI/MTLO (hi<=A or lo<=A) at the accepting edge, without asserting busy and without affecting the other register.
REQ-021 SHALL keep hi and lo stable throughout RUN (old values remain readable by mfhi/mflo until completion).
REQ-022 SHALL compute results from the latched operands only; A, B and md_op changes during RUN SHALL have no effect.
REQ-023 SHALL treat start=1 with md_op 6/7 when MADD is disabled as a no-op (no busy, no hi/lo change).

Reset
REQ-024 SHALL, while reset=1 and independent of clk, force busy=0, hi=0, lo=0, the counter to 0 and the state to IDLE.
REQ-025 SHALL discard any in-flight operation on reset mid-RUN, with no hi/lo write after release.
REQ-026 SHALL accept a new issue at the first posedge after reset deasserts.

Configuration
REQ-027 SHALL compile MADD (md_op 6) and MSUB (md_op 7) only when the macro MD_MADD_EN is defined: {hi,lo} <= {hi,lo} +/- signed(A*B), 5-cycle latency, using {hi,lo} as sampled at issue.
REQ-028 SHALL, when MD_MADD_EN is undefined, behave per REQ-023 and synthesize no accumulate adder.

Verification
REQ-029 SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-031 SHALL cover: DIVU with B=0 and prior hi=0x11, lo=0x22 -> after 10 cycles hi=0x11, lo=0x22.
REQ-032 SHALL cover: MTHI A=0xDEADBEEF -> hi=0xDEADBEEF next edge, busy stays 0, lo unchanged; a start issued during RUN is ignored.
REQ-033 SHALL cover: reset asserted on cycle 3 of a MULT -> busy, hi and lo read 0 immediately and stay 0 after release.
REQ-034 SHALL cover, with MD_MADD_EN defined: hi=0, lo=10, MADD A=3, B=4 -> {hi,lo}=22 after 5 cycles; with MD_MADD_EN undefined the same stimulus leaves hi/lo unchanged.
